// File: rtl/box_layer.sv
// rtl/box_layer.sv - destructible box map, occupancy query and box sprite render pipeline (optional BOX_BURN_ANIM_EN)
module box_layer #(
    parameter int          X_OFFSET   = 80,
    parameter int          Y_OFFSET   = 64,
    parameter int          GRID_COLS  = 15,
    parameter int          GRID_ROWS  = 11,
    parameter logic [11:0] TRANSP     = 12'hF0F,
    parameter int          BURN_TICKS = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        clr_valid,
    input  logic [3:0]  clr_row,
    input  logic [3:0]  clr_col,
    input  logic [3:0]  q_row,
    input  logic [3:0]  q_col,
    output logic        q_box,
    output logic [4:0]  rom_row,
    output logic [4:0]  rom_col,
    input  logic [11:0] rom_color,
    output logic        box_on,
    output logic [11:0] rgb
);

    localparam int NCELL = GRID_ROWS * GRID_COLS;
    localparam int IDX_W = $clog2(NCELL);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BOX   = 2'd1;
    localparam logic [1:0] ST_BURN  = 2'd2;

    localparam logic [9:0] X_OFF   = 10'(X_OFFSET);
    localparam logic [9:0] Y_OFF   = 10'(Y_OFFSET);
    localparam logic [9:0] ARENA_W = 10'(32 * GRID_COLS);
    localparam logic [9:0] ARENA_H = 10'(32 * GRID_ROWS);

    // Power-up map: pillars (odd row and odd col) and the three spawn cells are empty
    function automatic logic [1:0] init_state(input int idx);
        int r;
        int c;
        r = idx / GRID_COLS;
        c = idx % GRID_COLS;
        if ((r % 2 == 1) && (c % 2 == 1)) return ST_EMPTY;
        if ((r == 0 && c == 0) || (r == 0 && c == 1) || (r == 1 && c == 0)) return ST_EMPTY;
        return ST_BOX;
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] row, input logic [4:0] col);
        return IDX_W'(int'(row) * GRID_COLS + int'(col));
    endfunction

    logic [1:0] map_q [NCELL];
    logic [1:0] map_d [NCELL];

    logic        clr_in_range;
    logic        q_in_range;
    logic [IDX_W-1:0] clr_idx;
    logic [IDX_W-1:0] q_idx;

    assign clr_in_range = (int'(clr_row) < GRID_ROWS) && (int'(clr_col) < GRID_COLS);
    assign q_in_range   = (int'(q_row) < GRID_ROWS) && (int'(q_col) < GRID_COLS);
    assign clr_idx      = cell_idx(clr_row, {1'b0, clr_col});
    assign q_idx        = cell_idx(q_row, {1'b0, q_col});

    // Arena-relative pixel position; x below the offset wraps high and fails the width test
    logic [9:0]       xr;
    logic [9:0]       yr;
    logic             in_arena;
    logic [IDX_W-1:0] pix_idx;
    logic [1:0]       pix_state;

    assign xr       = x - X_OFF;
    assign yr       = y - Y_OFF;
    assign in_arena = video_on && (x >= X_OFF) && (xr < ARENA_W) && (y >= Y_OFF) && (yr < ARENA_H);
    assign pix_idx  = cell_idx(yr[8:5], xr[9:5]);
    assign pix_state = in_arena ? map_q[pix_idx] : ST_EMPTY;

`ifdef BOX_BURN_ANIM_EN
    localparam logic [1:0] BURN_CNT = 2'(BURN_TICKS);

    logic [1:0] cnt_q [NCELL];
    logic [1:0] cnt_d [NCELL];

    logic unused_bits;
    assign unused_bits = yr[9];

    // Next map: frame ticks age burning cells, then a destroy turns a BOX into a fresh BURN
    always_comb begin
        for (int i = 0; i < NCELL; i++) begin
            map_d[i] = map_q[i];
            cnt_d[i] = cnt_q[i];
            if (frame_tick && map_q[i] == ST_BURN) begin
                if (cnt_q[i] <= 2'd1) begin
                    map_d[i] = ST_EMPTY;
                    cnt_d[i] = 2'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] - 2'd1;
                end
            end
        end
        if (clr_valid && clr_in_range && map_q[clr_idx] == ST_BOX) begin
            map_d[clr_idx] = ST_BURN;
            cnt_d[clr_idx] = BURN_CNT;
        end
    end

    // Burn counters; cleared with the map
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCELL; i++) cnt_q[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NCELL; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    logic [2:0] unused_bits;
    assign unused_bits = {yr[9], frame_tick, BURN_TICKS[0]};

    // Next map: a destroy on a BOX cell empties it; everything else is left alone
    always_comb begin
        for (int i = 0; i < NCELL; i++) begin
            map_d[i] = map_q[i];
        end
        if (clr_valid && clr_in_range && map_q[clr_idx] == ST_BOX) begin
            map_d[clr_idx] = ST_EMPTY;
        end
    end
`endif

    // Occupancy map storage, reloaded with the arena layout on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCELL; i++) map_q[i] <= init_state(i);
        end else begin
            for (int i = 0; i < NCELL; i++) map_q[i] <= map_d[i];
        end
    end

    logic        q_box_q,   q_box_d;
    logic [4:0]  rom_row_q, rom_row_d;
    logic [4:0]  rom_col_q, rom_col_d;
    logic        hit1_q,    hit1_d;
    logic        burn1_q,   burn1_d;
    logic        hit2_q,    hit2_d;
    logic        burn2_q,   burn2_d;
    logic        box_on_q,  box_on_d;
    logic [11:0] rgb_q,     rgb_d;
    logic [11:0] dark_color;

    // Burn tint halves each 4-bit channel
    assign dark_color = {1'b0, rom_color[11:9], 1'b0, rom_color[7:5], 1'b0, rom_color[3:1]};

    // Query answer and three-stage render pipeline next-state; query reads the pre-update map
    always_comb begin
        q_box_d   = q_in_range ? (map_q[q_idx] != ST_EMPTY) : 1'b1;
        rom_row_d = yr[4:0];
        rom_col_d = xr[4:0];
        hit1_d    = in_arena && (pix_state != ST_EMPTY);
        burn1_d   = (pix_state == ST_BURN);
        hit2_d    = hit1_q;
        burn2_d   = burn1_q;
        box_on_d  = hit2_q && (rom_color != TRANSP);
        rgb_d     = 12'h000;
        if (box_on_d) begin
            rgb_d = burn2_q ? dark_color : rom_color;
        end
    end

    // Pipeline and query registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_box_q   <= 1'b0;
            rom_row_q <= 5'd0;
            rom_col_q <= 5'd0;
            hit1_q    <= 1'b0;
            burn1_q   <= 1'b0;
            hit2_q    <= 1'b0;
            burn2_q   <= 1'b0;
            box_on_q  <= 1'b0;
            rgb_q     <= 12'h000;
        end else begin
            q_box_q   <= q_box_d;
            rom_row_q <= rom_row_d;
            rom_col_q <= rom_col_d;
            hit1_q    <= hit1_d;
            burn1_q   <= burn1_d;
            hit2_q    <= hit2_d;
            burn2_q   <= burn2_d;
            box_on_q  <= box_on_d;
            rgb_q     <= rgb_d;
        end
    end

    assign q_box   = q_box_q;
    assign rom_row = rom_row_q;
    assign rom_col = rom_col_q;
    assign box_on  = box_on_q;
    assign rgb     = rgb_q;

endmodule

// File: tb/tb_box_layer.sv
// tb/tb_box_layer.sv - self-checking bench for box_layer with a scoreboard for the render stream
module tb_box_layer;

    localparam int          ROWS   = 11;
    localparam int          COLS   = 15;
    localparam logic [11:0] TRANSP = 12'hF0F;
`ifdef BOX_BURN_ANIM_EN
    localparam bit BURN_EN = 1'b1;
`else
    localparam bit BURN_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [9:0]  x, y;
    logic        video_on, frame_tick, clr_valid;
    logic [3:0]  clr_row, clr_col, q_row, q_col;
    logic        q_box;
    logic [4:0]  rom_row, rom_col;
    logic [11:0] rom_color;
    logic        box_on;
    logic [11:0] rgb;

    logic        use_fixed;
    logic [11:0] fixed_color;

    int pass_cnt;
    int total_cnt;

    int mstate [ROWS][COLS];
    int mcnt   [ROWS][COLS];
    logic [12:0] sb [$];

    box_layer #(
        .X_OFFSET(80), .Y_OFFSET(64), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
        .TRANSP(TRANSP), .BURN_TICKS(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .clr_valid(clr_valid), .clr_row(clr_row),
        .clr_col(clr_col), .q_row(q_row), .q_col(q_col), .q_box(q_box),
        .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
        .box_on(box_on), .rgb(rgb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: either a fixed texel or an address-derived pattern
    always @(posedge clk) rom_color <= use_fixed ? fixed_color : {2'b00, rom_row, rom_col};

    function automatic void model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mcnt[r][c] = 0;
                if ((r % 2 == 1) && (c % 2 == 1)) mstate[r][c] = 0;
                else if (r + c <= 1) mstate[r][c] = 0;
                else mstate[r][c] = 1;
            end
    endfunction

    function automatic void model_destroy(input int r, input int c);
        if (r < ROWS && c < COLS && mstate[r][c] == 1) begin
            if (BURN_EN) begin mstate[r][c] = 2; mcnt[r][c] = 3; end
            else mstate[r][c] = 0;
        end
    endfunction

    function automatic void model_tick();
        if (BURN_EN)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (mstate[r][c] == 2) begin
                        mcnt[r][c]--;
                        if (mcnt[r][c] == 0) mstate[r][c] = 0;
                    end
    endfunction

    function automatic logic model_q(input int r, input int c);
        if (r >= ROWS || c >= COLS) return 1'b1;
        return mstate[r][c] != 0;
    endfunction

    function automatic logic [12:0] exp_pix(input int px, input int py, input bit vo,
                                            input bit fixed, input logic [11:0] fc);
        int xr, yr, st;
        logic [11:0] color;
        xr = px - 80;
        yr = py - 64;
        if (!(vo && xr >= 0 && xr < 480 && yr >= 0 && yr < 352)) return 13'h0;
        st = mstate[yr / 32][xr / 32];
        color = fixed ? fc : 12'((yr % 32) * 32 + (xr % 32));
        if (st == 0 || color == TRANSP) return 13'h0;
        return {1'b1, (st == 2) ? ((color >> 1) & 12'h777) : color};
    endfunction

    task automatic do_query(input int r, input int c);
        q_row = 4'(r);
        q_col = 4'(c);
        @(posedge clk); #1;
    endtask

    task automatic do_destroy(input int r, input int c);
        clr_row = 4'(r); clr_col = 4'(c); clr_valid = 1'b1;
        @(posedge clk); #1;
        clr_valid = 1'b0;
        model_destroy(r, c);
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        model_tick();
    endtask

    task automatic render(input int px, input int py, input logic vo);
        x = 10'(px); y = 10'(py); video_on = vo;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int qr [5] = '{0, 1, 0, 2, 11};
        int qc [5] = '{0, 1, 2, 2, 0};
        logic [12:0] exp_vals;
        reset_n = 1'b0;
        x = '0; y = '0; video_on = 0; frame_tick = 0; clr_valid = 0;
        clr_row = '0; clr_col = '0; q_row = '0; q_col = '0;
        use_fixed = 1'b1; fixed_color = 12'h8A3;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({rom_row, rom_col, q_box, box_on, rgb} !== 24'h0)
            $display("FAIL reset_outputs: got %0h expected 0", {rom_row, rom_col, q_box, box_on, rgb});
        else pass_cnt++;
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            do_query(qr[i], qc[i]);
            exp_vals = {12'h0, (i >= 2)};
            total_cnt++;
            if (q_box !== exp_vals[0])
                $display("FAIL reset_query(%0d,%0d): got %b expected %b", qr[i], qc[i], q_box, exp_vals[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_pixel();
        use_fixed = 1'b1; fixed_color = 12'h8A3;
        x = 10'd85; y = 10'd135; video_on = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (rom_row !== 5'd7 || rom_col !== 5'd5)
            $display("FAIL rom_addr: got %0d/%0d expected 7/5", rom_row, rom_col);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (box_on !== 1'b1 || rgb !== 12'h8A3)
            $display("FAIL pixel_opaque: got %b/%h expected 1/8a3", box_on, rgb);
        else pass_cnt++;
        fixed_color = TRANSP;
        render(85, 135, 1'b1);
        total_cnt++;
        if (box_on !== 1'b0 || rgb !== 12'h000)
            $display("FAIL pixel_transp: got %b/%h expected 0/000", box_on, rgb);
        else pass_cnt++;
        fixed_color = 12'h8A3;
        render(79, 100, 1'b1);
        total_cnt++;
        if (box_on !== 1'b0 || rgb !== 12'h000)
            $display("FAIL pixel_left_of_arena: got %b/%h expected 0/000", box_on, rgb);
        else pass_cnt++;
        render(85, 135, 1'b0);
        total_cnt++;
        if (box_on !== 1'b0 || rgb !== 12'h000)
            $display("FAIL pixel_blanked: got %b/%h expected 0/000", box_on, rgb);
        else pass_cnt++;
    endtask

    task automatic test_destroy();
        logic [12:0] e;
        do_destroy(2, 0);
        do_query(2, 0);
        total_cnt++;
        if (q_box !== model_q(2, 0))
            $display("FAIL destroy_query(2,0): got %b expected %b", q_box, model_q(2, 0));
        else pass_cnt++;
        render(85, 135, 1'b1);
        e = exp_pix(85, 135, 1'b1, 1'b1, fixed_color);
        total_cnt++;
        if ({box_on, rgb} !== e)
            $display("FAIL destroy_render(2,0): got %h expected %h", {box_on, rgb}, e);
        else pass_cnt++;
        do_destroy(1, 1);
        do_destroy(11, 0);
        do_destroy(0, 15);
        do_query(1, 1);
        total_cnt++;
        if (q_box !== 1'b0)
            $display("FAIL pillar_query(1,1): got %b expected 0", q_box);
        else pass_cnt++;
        // query and destroy on the same cell in one cycle
        q_row = 4'd4; q_col = 4'd4;
        clr_row = 4'd4; clr_col = 4'd4; clr_valid = 1'b1;
        @(posedge clk); #1;
        clr_valid = 1'b0;
        total_cnt++;
        if (q_box !== model_q(4, 4))
            $display("FAIL same_cycle_query: got %b expected %b", q_box, model_q(4, 4));
        else pass_cnt++;
        model_destroy(4, 4);
        do_query(4, 4);
        total_cnt++;
        if (q_box !== model_q(4, 4))
            $display("FAIL after_same_cycle_query: got %b expected %b", q_box, model_q(4, 4));
        else pass_cnt++;
    endtask

    task automatic test_burn();
        logic [12:0] e;
        use_fixed = 1'b1; fixed_color = 12'hFA6;
        do_destroy(0, 2);
        for (int t = 0; t < 4; t++) begin
            do_query(0, 2);
            total_cnt++;
            if (q_box !== model_q(0, 2))
                $display("FAIL burn_query t%0d: got %b expected %b", t, q_box, model_q(0, 2));
            else pass_cnt++;
            render(147, 69, 1'b1);
            e = exp_pix(147, 69, 1'b1, 1'b1, fixed_color);
            total_cnt++;
            if ({box_on, rgb} !== e)
                $display("FAIL burn_render t%0d: got %h expected %h", t, {box_on, rgb}, e);
            else pass_cnt++;
            if (t < 3) do_tick();
        end
    endtask

    task automatic test_map_sweep();
        for (int i = 0; i < 20; i++) do_destroy($urandom_range(0, 12), $urandom_range(0, 15));
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                do_query(r, c);
                total_cnt++;
                if (q_box !== model_q(r, c))
                    $display("FAIL sweep_query(%0d,%0d): got %b expected %b", r, c, q_box, model_q(r, c));
                else pass_cnt++;
            end
    endtask

    task automatic test_stream();
        int bx [7] = '{80, 79, 559, 560, 559, 80, 300};
        int by [7] = '{64, 64, 415, 415, 416, 63, 200};
        int px, py;
        bit vo;
        logic [12:0] e;
        use_fixed = 1'b0;
        sb.delete();
        for (int i = 0; i < 162; i++) begin
            if (i < 7) begin px = bx[i]; py = by[i]; vo = (i != 6); end
            else if (i < 160) begin
                px = $urandom_range(40, 620); py = $urandom_range(30, 450);
                vo = ($urandom_range(0, 7) != 0);
            end else begin px = 0; py = 0; vo = 0; end
            x = 10'(px); y = 10'(py); video_on = vo;
            @(posedge clk); #1;
            sb.push_back(exp_pix(px, py, vo, 1'b0, 12'h0));
            if (sb.size() == 3) begin
                e = sb.pop_front();
                total_cnt++;
                if ({box_on, rgb} !== e)
                    $display("FAIL stream_pixel %0d: got %h expected %h", i - 2, {box_on, rgb}, e);
                else pass_cnt++;
            end
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        logic [12:0] e;
        use_fixed = 1'b1; fixed_color = 12'h8A3;
        render(209, 194, 1'b1);
        e = exp_pix(209, 194, 1'b1, 1'b1, fixed_color);
        total_cnt++;
        if ({box_on, rgb} !== e)
            $display("FAIL pre_reset_render: got %h expected %h", {box_on, rgb}, e);
        else pass_cnt++;
        clr_row = 4'd4; clr_col = 4'd2; clr_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({rom_row, rom_col, q_box, box_on, rgb} !== 24'h0)
            $display("FAIL async_reset_outputs: got %h expected 0", {rom_row, rom_col, q_box, box_on, rgb});
        else pass_cnt++;
        clr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (box_on !== 1'b0 || rgb !== 12'h000)
            $display("FAIL held_reset_outputs: got %b/%h expected 0/000", box_on, rgb);
        else pass_cnt++;
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        do_query(4, 2);
        total_cnt++;
        if (q_box !== 1'b1)
            $display("FAIL reload_query(4,2): got %b expected 1", q_box);
        else pass_cnt++;
        render(209, 194, 1'b1);
        total_cnt++;
        if (box_on !== 1'b1 || rgb !== 12'h8A3)
            $display("FAIL reload_render(4,4): got %b/%h expected 1/8a3", box_on, rgb);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_pixel();
        test_destroy();
        test_burn();
        test_map_sweep();
        test_stream();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
